axi_lite_ctrl_regs: RTL and testbench
=====================================

# axi_lite_ctrl_regs

AXI4-Lite slave control/status register bank sitting directly downstream of the PCIe-to-AXI-Lite bridge master port, in the `user_clk` domain, as a peer of the block-RAM slave. It is reachable from host BAR accesses. It provides:
- a design ID
- control and interrupt-mask registers
- status sampling
- a free-running cycle counter
- sticky write-1-to-clear interrupt flags
- four scratch registers

## Interface
Parameters:
- `DESIGN_ID`, 32'hAC70_1001, value returned at offset 0x00
- `NUM_IRQ`, 8, interrupt source count (1..32)

Ports:
- `user_clk` input 1: the only clock; every output is registered on its rising edge.
- `user_reset` input 1: synchronous, active-high reset.
- `s_axi_awaddr` input 32, `s_axi_awvalid` input 1, `s_axi_awready` output 1: write address channel.
- `s_axi_wdata` input 32, `s_axi_wstrb` input 4, `s_axi_wvalid` input 1, `s_axi_wready` output 1: write data channel.
- `s_axi_bresp` output 2, `s_axi_bvalid` output 1, `s_axi_bready` input 1: write response channel.
- `s_axi_araddr` input 32, `s_axi_arvalid` input 1, `s_axi_arready` output 1: read address channel.
- `s_axi_rdata` output 32, `s_axi_rresp` output 2, `s_axi_rvalid` output 1, `s_axi_rready` input 1: read data channel.
- `ctrl_out` output 32: CONTROL register contents.
- `status_in` input 32: status word, already synchronous to `user_clk`.
- `irq_in` input NUM_IRQ: level/pulse interrupt sources.
- `irq_out` output 1: registered OR of (pending AND mask).

## Operation
- Address decode uses `addr[11:2]`. `addr[1:0]` and `addr[31:12]` are ignored, so the map aliases every 4 KB.
- Register map:
  - 0x00 ID, RO, returns `DESIGN_ID`.
  - 0x04 CONTROL, RW, byte-strobed, reset 0.
  - 0x08 STATUS, RO, returns `status_in` as sampled in the AR handshake cycle.
  - 0x0C CYCLES, RO: 32-bit free-running counter. Cleared by reset, +1 every cycle, wraps 0xFFFF_FFFF→0.
  - 0x10 IRQ_PEND, RW1C, bits [NUM_IRQ-1:0]. A bit is set in any cycle its `irq_in` bit is high.
  - 0x14 IRQ_MASK, RW, bits [NUM_IRQ-1:0], byte-strobed, reset 0.
  - 0x20/0x24/0x28/0x2C SCRATCH0..3, RW, byte-strobed, reset 0.
- Unused bits of IRQ_PEND and IRQ_MASK read 0.
- Any other offset is unmapped:
  - read returns 0xDEAD_BEEF with `rresp`=2'b10 (SLVERR);
  - write has no effect, with `bresp`=2'b10.
- Mapped accesses respond OKAY (2'b00). A write to an RO register is ignored and responds OKAY.
- IRQ_PEND: if a set and a W1C clear hit the same bit in the same cycle, the set wins. `wstrb` gates the clear per byte.
- Write path:
  - AW and W have independent one-entry holding buffers.
  - `awready` = AW buffer empty AND `bvalid` low; `wready` = W buffer empty AND `bvalid` low.
  - AW and W may arrive in either order or in the same cycle.
  - On the first cycle with both buffers full, the register is updated at the end of that cycle, both buffers are emptied and `bvalid` is set.
  - `bvalid` holds, with `bresp` stable, until `bready`. It clears on the cycle after the handshake.
- Read path:
  - `arready` = `rvalid` low.
  - On the AR handshake, `rdata`/`rresp` are registered and `rvalid` is set.
  - `rdata`, `rresp` and `rvalid` hold stable until the `rready` handshake.
  - Reads have no side effects.
- Read/write interaction: the read and write paths are fully independent. A read whose AR handshake coincides with a write commit to the same register returns the pre-commit value.
- `irq_out` is registered: `irq_out` = |(IRQ_PEND & IRQ_MASK) as of the previous cycle.

## Timing
- Reset values:
  - all ready/valid outputs 0;
  - `bresp`, `rresp`, `rdata`, `ctrl_out`, `irq_out` = 0;
  - all registers, buffers and CYCLES = 0.
- `awready`, `wready` and `arready` go high in the first cycle after `user_reset` deasserts.
- Reset applied mid-transaction: any captured AW/W and any pending B/R are discarded, with no partial register update. Outputs return to reset values at the next edge.
- Write latency:
  - AW and W handshakes in cycle N → buffers full in N+1 → register updated at end of N+1 → `bvalid` high from N+2.
  - Throughput is one write per 3 cycles when `bready` is held high.
- Read latency: AR handshake in cycle N → `rvalid` high in N+1. One read per 2 cycles when `rready` is held high.
- Backpressure: if `bready` or `rready` stays low, the corresponding ready outputs stay low indefinitely; there is no timeout.
- CONTROL write visibility: `ctrl_out` changes in the same cycle `bvalid` rises.

## Test plan
- **Reset and ID/CYCLES read.** Release reset, read 0x00 → 0xAC70_1001, OKAY. Read 0x0C twice, 10 cycles apart → difference of 12 (10 cycles apart plus the 2-cycle read cadence).
- **Write channel ordering.**
  - Write 0x20 = 0x1234_5678 with W three cycles before AW, then read → 0x1234_5678.
  - Write 0x20 with `wstrb`=4'b0010, data 0xFFFF_FFFF → readback 0x1234_FF78.
  - Same-cycle AW+W → `bvalid` exactly 2 cycles after the handshake.
- **IRQ flags.**
  - Pulse `irq_in[3]` for 1 cycle with mask 0 → IRQ_PEND reads 0x08, `irq_out` stays 0.
  - Write mask 0x08 → `irq_out`=1.
  - W1C 0x08 in the same cycle as another `irq_in[3]` pulse → bit stays 1.
  - A later W1C with no pulse → bit clears and `irq_out` drops 1 cycle later.
- **Unmapped and RO accesses.**
  - Read 0x40 → 0xDEAD_BEEF, SLVERR.
  - Write 0x40 → SLVERR, no register changes.
  - Write 0x00 → OKAY, ID unchanged.
  - Read 0x1004 → aliases CONTROL.
- **Backpressure.**
  - Hold `rready`=0 for 20 cycles → `rvalid`/`rdata` stable and `arready`=0 throughout.
  - Hold `bready`=0 → `awready`=`wready`=0 throughout.
  - Release → exactly one response each.
- **Reset mid-write.** Capture AW only, assert `user_reset` for 1 cycle, then send W only → no `bvalid` and no register change. After a full AW+W, normal operation resumes.

Source files
------------

// File: rtl/axi_lite_ctrl_regs.sv
// AXI4-Lite slave register bank: design ID, CONTROL, STATUS sample, CYCLES counter,
// sticky W1C interrupt flags with mask, and four scratch registers.
module axi_lite_ctrl_regs #(
  parameter logic [31:0] DESIGN_ID = 32'hAC70_1001,
  parameter int unsigned NUM_IRQ   = 8
) (
  input  logic               user_clk,
  input  logic               user_reset,
  input  logic [31:0]        s_axi_awaddr,
  input  logic               s_axi_awvalid,
  output logic               s_axi_awready,
  input  logic [31:0]        s_axi_wdata,
  input  logic [3:0]         s_axi_wstrb,
  input  logic               s_axi_wvalid,
  output logic               s_axi_wready,
  output logic [1:0]         s_axi_bresp,
  output logic               s_axi_bvalid,
  input  logic               s_axi_bready,
  input  logic [31:0]        s_axi_araddr,
  input  logic               s_axi_arvalid,
  output logic               s_axi_arready,
  output logic [31:0]        s_axi_rdata,
  output logic [1:0]         s_axi_rresp,
  output logic               s_axi_rvalid,
  input  logic               s_axi_rready,
  output logic [31:0]        ctrl_out,
  input  logic [31:0]        status_in,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq_out
);

  typedef enum logic [9:0] {
    IDX_ID     = 10'h000,
    IDX_CTRL   = 10'h001,
    IDX_STATUS = 10'h002,
    IDX_CYCLES = 10'h003,
    IDX_PEND   = 10'h004,
    IDX_MASK   = 10'h005,
    IDX_SCR0   = 10'h008,
    IDX_SCR1   = 10'h009,
    IDX_SCR2   = 10'h00A,
    IDX_SCR3   = 10'h00B
  } reg_idx_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic               r_live;
  logic               r_aw_full;
  logic [9:0]         r_aw_idx;
  logic               r_w_full;
  logic [31:0]        r_wdata;
  logic [3:0]         r_wstrb;
  logic               r_bvalid;
  logic [1:0]         r_bresp;
  logic               r_rvalid;
  logic [31:0]        r_rdata;
  logic [1:0]         r_rresp;
  logic [31:0]        r_ctrl;
  logic [31:0]        r_cycles;
  logic [NUM_IRQ-1:0] r_pend;
  logic [NUM_IRQ-1:0] r_mask;
  logic               r_irq;
  logic [31:0]        r_scratch [4];

  logic               w_aw_hs;
  logic               w_w_hs;
  logic               w_ar_hs;
  logic               w_commit;
  logic [31:0]        w_bmask;
  logic [31:0]        w_wbits;
  logic [31:0]        w_pend32;
  logic [31:0]        w_mask32;
  logic [31:0]        w_mask_wr;
  logic [NUM_IRQ-1:0] w_clr;
  logic [31:0]        w_rd_data;
  logic [1:0]         w_rd_resp;
  logic [1:0]         w_wr_resp;
  logic               w_unused;

  function automatic logic [31:0] f_merge(input logic [31:0] old_d, input logic [31:0] new_d,
                                          input logic [31:0] m);
    return (old_d & ~m) | (new_d & m);
  endfunction

  // r_live keeps every ready low until the first cycle after reset is released
  assign s_axi_awready = r_live & ~r_aw_full & ~r_bvalid;
  assign s_axi_wready  = r_live & ~r_w_full & ~r_bvalid;
  assign s_axi_arready = r_live & ~r_rvalid;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = r_rresp;
  assign ctrl_out      = r_ctrl;
  assign irq_out       = r_irq;

  assign w_aw_hs   = s_axi_awvalid & s_axi_awready;
  assign w_w_hs    = s_axi_wvalid & s_axi_wready;
  assign w_ar_hs   = s_axi_arvalid & s_axi_arready;
  assign w_commit  = r_aw_full & r_w_full;
  assign w_bmask   = {{8{r_wstrb[3]}}, {8{r_wstrb[2]}}, {8{r_wstrb[1]}}, {8{r_wstrb[0]}}};
  assign w_wbits   = r_wdata & w_bmask;
  assign w_mask_wr = f_merge(w_mask32, r_wdata, w_bmask);
  assign w_unused  = ^{s_axi_awaddr[31:12], s_axi_awaddr[1:0], s_axi_araddr[31:12],
                       s_axi_araddr[1:0], w_mask_wr, w_wbits};

  always_comb begin
    w_pend32 = '0;
    w_mask32 = '0;
    w_pend32[NUM_IRQ-1:0] = r_pend;
    w_mask32[NUM_IRQ-1:0] = r_mask;
    w_clr = '0;
    if (w_commit && (r_aw_idx == IDX_PEND)) w_clr = w_wbits[NUM_IRQ-1:0];
  end

  always_comb begin
    w_rd_data = 32'hDEAD_BEEF;
    w_rd_resp = RESP_SLVERR;
    case (s_axi_araddr[11:2])
      IDX_ID:     begin w_rd_data = DESIGN_ID;  w_rd_resp = RESP_OKAY; end
      IDX_CTRL:   begin w_rd_data = r_ctrl;     w_rd_resp = RESP_OKAY; end
      IDX_STATUS: begin w_rd_data = status_in;  w_rd_resp = RESP_OKAY; end
      IDX_CYCLES: begin w_rd_data = r_cycles;   w_rd_resp = RESP_OKAY; end
      IDX_PEND:   begin w_rd_data = w_pend32;   w_rd_resp = RESP_OKAY; end
      IDX_MASK:   begin w_rd_data = w_mask32;   w_rd_resp = RESP_OKAY; end
      IDX_SCR0, IDX_SCR1, IDX_SCR2, IDX_SCR3: begin
        w_rd_data = r_scratch[s_axi_araddr[3:2]];
        w_rd_resp = RESP_OKAY;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_wr_resp = RESP_SLVERR;
    case (r_aw_idx)
      IDX_ID, IDX_CTRL, IDX_STATUS, IDX_CYCLES, IDX_PEND, IDX_MASK,
      IDX_SCR0, IDX_SCR1, IDX_SCR2, IDX_SCR3: w_wr_resp = RESP_OKAY;
      default: ;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      r_live    <= 1'b0;
      r_aw_full <= 1'b0;
      r_aw_idx  <= '0;
      r_w_full  <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= '0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= '0;
      r_ctrl    <= '0;
      r_cycles  <= '0;
      r_pend    <= '0;
      r_mask    <= '0;
      r_irq     <= 1'b0;
      r_scratch <= '{default: '0};
    end else begin
      r_live   <= 1'b1;
      r_cycles <= r_cycles + 32'd1;
      r_irq    <= |(r_pend & r_mask);
      // a same-cycle set from irq_in overrides the W1C clear
      r_pend   <= (r_pend & ~w_clr) | irq_in;
      if (w_aw_hs) begin
        r_aw_full <= 1'b1;
        r_aw_idx  <= s_axi_awaddr[11:2];
      end
      if (w_w_hs) begin
        r_w_full <= 1'b1;
        r_wdata  <= s_axi_wdata;
        r_wstrb  <= s_axi_wstrb;
      end
      if (w_commit) begin
        r_aw_full <= 1'b0;
        r_w_full  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_wr_resp;
        case (r_aw_idx)
          IDX_CTRL: r_ctrl <= f_merge(r_ctrl, r_wdata, w_bmask);
          IDX_MASK: r_mask <= w_mask_wr[NUM_IRQ-1:0];
          IDX_SCR0, IDX_SCR1, IDX_SCR2, IDX_SCR3:
            r_scratch[r_aw_idx[1:0]] <= f_merge(r_scratch[r_aw_idx[1:0]], r_wdata, w_bmask);
          default: ;
        endcase
      end else if (r_bvalid && s_axi_bready) begin
        r_bvalid <= 1'b0;
      end
      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_data;
        r_rresp  <= w_rd_resp;
      end else if (r_rvalid && s_axi_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_ctrl_regs.sv
// Bench for axi_lite_ctrl_regs: directed AXI-Lite traffic, a transaction-level
// register model compared against the DUT every cycle, plus literal expectations.
module tb_axi_lite_ctrl_regs;

  localparam logic [31:0] ID = 32'hAC70_1001;
  localparam int unsigned NI = 8;
  localparam logic [31:0] PM = 32'h0000_00FF;

  logic          user_clk, user_reset;
  logic [31:0]   s_axi_awaddr, s_axi_wdata, s_axi_araddr, s_axi_rdata, ctrl_out, status_in;
  logic          s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [3:0]    s_axi_wstrb;
  logic [1:0]    s_axi_bresp, s_axi_rresp;
  logic          s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic          s_axi_rvalid, s_axi_rready, irq_out;
  logic [NI-1:0] irq_in;

  int checks = 0;
  int errors = 0;
  int tb_cyc = 0;
  bit chk_en = 0;

  axi_lite_ctrl_regs #(.DESIGN_ID(ID), .NUM_IRQ(NI)) dut (
    .user_clk(user_clk), .user_reset(user_reset),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .ctrl_out(ctrl_out),
    .status_in(status_in), .irq_in(irq_in), .irq_out(irq_out)
  );

  initial user_clk = 1'b0;
  always #5 user_clk = ~user_clk;
  always @(posedge user_clk) tb_cyc <= tb_cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic        m_live, m_awh, m_wh, m_bv, m_rv, m_irq;
  logic [31:0] m_awa, m_wd, m_rd, m_ctrl, m_mask, m_pend, m_cyc;
  logic [3:0]  m_ws;
  logic [1:0]  m_br, m_rr;
  logic [31:0] m_scr [4];
  logic        m_commit, m_awr, m_wr, m_arr;

  assign m_commit = m_awh & m_wh;
  assign m_awr    = m_live & !m_awh & !m_bv;
  assign m_wr     = m_live & !m_wh & !m_bv;
  assign m_arr    = m_live & !m_rv;

  function automatic logic [31:0] bm(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    return (o & ~bm(s)) | (n & bm(s));
  endfunction

  function automatic bit mapped(input logic [31:0] a);
    int unsigned k;
    k = int'(a[11:2]);
    return (k <= 5) || (k >= 8 && k <= 11);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    case (int'(a[11:2]))
      0: return ID;
      1: return m_ctrl;
      2: return status_in;
      3: return m_cyc;
      4: return m_pend;
      5: return m_mask;
      8, 9, 10, 11: return m_scr[a[3:2]];
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always @(posedge user_clk) begin
    if (user_reset) begin
      m_live <= 0; m_awh <= 0; m_wh <= 0; m_bv <= 0; m_rv <= 0; m_irq <= 0;
      m_awa <= '0; m_wd <= '0; m_ws <= '0; m_br <= '0; m_rd <= '0; m_rr <= '0;
      m_ctrl <= '0; m_mask <= '0; m_pend <= '0; m_cyc <= '0; m_scr <= '{default: '0};
    end else begin
      m_live <= 1;
      m_cyc  <= m_cyc + 1;
      m_irq  <= |(m_pend & m_mask);
      m_pend <= ((m_pend & ~((m_commit && m_awa[11:2] == 10'd4) ? (m_wd & bm(m_ws)) : 32'h0))
                 | 32'(irq_in)) & PM;
      if (m_commit) begin
        m_awh <= 0; m_wh <= 0; m_bv <= 1;
        m_br  <= mapped(m_awa) ? 2'b00 : 2'b10;
        case (int'(m_awa[11:2]))
          1: m_ctrl <= mrg(m_ctrl, m_wd, m_ws);
          5: m_mask <= mrg(m_mask, m_wd, m_ws) & PM;
          8, 9, 10, 11: m_scr[m_awa[3:2]] <= mrg(m_scr[m_awa[3:2]], m_wd, m_ws);
          default: ;
        endcase
      end else begin
        if (s_axi_awvalid && m_awr) begin m_awh <= 1; m_awa <= s_axi_awaddr; end
        if (s_axi_wvalid && m_wr) begin m_wh <= 1; m_wd <= s_axi_wdata; m_ws <= s_axi_wstrb; end
        if (m_bv && s_axi_bready) m_bv <= 0;
      end
      if (m_rv) begin
        if (s_axi_rready) m_rv <= 0;
      end else if (s_axi_arvalid && m_live) begin
        m_rv <= 1;
        m_rd <= m_read(s_axi_araddr);
        m_rr <= mapped(s_axi_araddr) ? 2'b00 : 2'b10;
      end
    end
  end

  always @(negedge user_clk) begin
    if (chk_en) begin
      chk("awready", s_axi_awready, m_awr);
      chk("wready", s_axi_wready, m_wr);
      chk("arready", s_axi_arready, m_arr);
      chk("bvalid", s_axi_bvalid, m_bv);
      chk("rvalid", s_axi_rvalid, m_rv);
      if (m_bv) chk("bresp", s_axi_bresp, m_br);
      if (m_rv) begin
        chk("rdata", s_axi_rdata, m_rd);
        chk("rresp", s_axi_rresp, m_rr);
      end
      chk("ctrl_out", ctrl_out, m_ctrl);
      chk("irq_out", irq_out, m_irq);
    end
  end

  // ---------------- transaction tasks ----------------
  task automatic step();
    @(posedge user_clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    bit got;
    s_axi_araddr  = a;
    s_axi_arvalid = 1;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin @(negedge user_clk); got = s_axi_arready; end
    step();
    s_axi_arvalid = 0;
    chk("ar_handshake", 32'(got), 1);
    got = 0;
    d = 'x; r = 'x;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge user_clk);
      if (s_axi_rvalid) begin got = 1; d = s_axi_rdata; r = s_axi_rresp; end
    end
    chk("r_arrival", 32'(got), 1);
    step();
  endtask

  // lead > 0: W issued lead cycles before AW; lead < 0: AW first; 0: same cycle
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int lead, output logic [1:0] resp, output int lat);
    int aw_c, w_c, b_c;
    aw_c = -1; w_c = -1; b_c = -1;
    fork
      begin
        repeat (lead < 0 ? -lead : 0) step();
        s_axi_awaddr = a; s_axi_awvalid = 1;
        for (int i = 0; i < 50 && aw_c < 0; i++) begin
          @(negedge user_clk);
          if (s_axi_awready) aw_c = tb_cyc;
        end
        step();
        s_axi_awvalid = 0;
      end
      begin
        repeat (lead > 0 ? lead : 0) step();
        s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1;
        for (int i = 0; i < 50 && w_c < 0; i++) begin
          @(negedge user_clk);
          if (s_axi_wready) w_c = tb_cyc;
        end
        step();
        s_axi_wvalid = 0;
      end
    join
    chk("aw_handshake", 32'(aw_c >= 0), 1);
    chk("w_handshake", 32'(w_c >= 0), 1);
    resp = 'x;
    for (int i = 0; i < 50 && b_c < 0; i++) begin
      @(negedge user_clk);
      if (s_axi_bvalid) begin b_c = tb_cyc; resp = s_axi_bresp; end
    end
    chk("b_arrival", 32'(b_c >= 0), 1);
    lat = b_c - ((aw_c > w_c) ? aw_c : w_c);
    step();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] d, c1, c2;
    logic [1:0]  r;
    int          lat, cnt;
    bit          got;

    user_reset = 1; s_axi_awaddr = '0; s_axi_awvalid = 0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wvalid = 0; s_axi_bready = 1; s_axi_araddr = '0; s_axi_arvalid = 0; s_axi_rready = 1;
    status_in = 32'h0; irq_in = '0;
    repeat (3) step();
    chk_en = 1;
    chk("rst_awready", s_axi_awready, 0);
    chk("rst_rdata", s_axi_rdata, 0);
    chk("rst_ctrl", ctrl_out, 0);
    user_reset = 0;
    step();
    chk("post_rst_awready", s_axi_awready, 1);
    chk("post_rst_arready", s_axi_arready, 1);

    rd(32'h00, d, r);
    chk("id", d, 32'hAC70_1001);
    chk("id_resp", r, 2'b00);
    rd(32'h0C, c1, r);
    repeat (10) step();
    rd(32'h0C, c2, r);
    chk("cycles_delta", c2 - c1, 32'd12);

    wr(32'h20, 32'h1234_5678, 4'hF, 3, r, lat);
    chk("w_first_resp", r, 2'b00);
    rd(32'h20, d, r);
    chk("scr0", d, 32'h1234_5678);
    wr(32'h20, 32'hFFFF_FFFF, 4'b0010, -2, r, lat);
    rd(32'h20, d, r);
    chk("scr0_strb", d, 32'h1234_FF78);
    wr(32'h24, 32'hCAFE_F00D, 4'hF, 0, r, lat);
    chk("same_cycle_lat", 32'(lat), 2);

    status_in = 32'h5A5A_1234;
    rd(32'h08, d, r);
    chk("status", d, 32'h5A5A_1234);

    irq_in = 8'h08; step(); irq_in = '0;
    repeat (2) step();
    rd(32'h10, d, r);
    chk("pend_set", d, 32'h08);
    chk("irq_masked", irq_out, 0);
    wr(32'h14, 32'h08, 4'hF, 0, r, lat);
    chk("irq_on", irq_out, 1);
    fork
      wr(32'h10, 32'h08, 4'hF, 0, r, lat);
      begin step(); irq_in = 8'h08; step(); irq_in = '0; end
    join
    rd(32'h10, d, r);
    chk("set_beats_clear", d, 32'h08);
    wr(32'h10, 32'hFF, 4'b1110, 0, r, lat);
    rd(32'h10, d, r);
    chk("w1c_strb_gated", d, 32'h08);
    wr(32'h10, 32'h08, 4'hF, 0, r, lat);
    rd(32'h10, d, r);
    chk("pend_cleared", d, 32'h00);
    chk("irq_off", irq_out, 0);

    rd(32'h40, d, r);
    chk("unmapped_rdata", d, 32'hDEAD_BEEF);
    chk("unmapped_rresp", r, 2'b10);
    wr(32'h40, 32'h0, 4'hF, 0, r, lat);
    chk("unmapped_bresp", r, 2'b10);
    rd(32'h20, d, r);
    chk("scr0_kept", d, 32'h1234_FF78);
    wr(32'h00, 32'hFFFF_FFFF, 4'hF, 0, r, lat);
    chk("ro_bresp", r, 2'b00);
    rd(32'h00, d, r);
    chk("id_kept", d, 32'hAC70_1001);
    wr(32'h04, 32'hA5A5_0F0F, 4'hF, -1, r, lat);
    chk("ctrl_out_val", ctrl_out, 32'hA5A5_0F0F);
    rd(32'h1004, d, r);
    chk("alias_ctrl", d, 32'hA5A5_0F0F);
    rd(32'h07, d, r);
    chk("lowbits_ignored", d, 32'hA5A5_0F0F);

    s_axi_rready = 0;
    s_axi_araddr = 32'h24; s_axi_arvalid = 1;
    step();
    s_axi_araddr = 32'h20;
    for (int i = 0; i < 20; i++) begin
      @(negedge user_clk);
      chk("rstall_rvalid", s_axi_rvalid, 1);
      chk("rstall_rdata", s_axi_rdata, 32'hCAFE_F00D);
      chk("rstall_arready", s_axi_arready, 0);
    end
    step();
    s_axi_arvalid = 0; s_axi_rready = 1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin @(negedge user_clk); if (s_axi_rvalid) cnt++; end
    chk("r_release_count", 32'(cnt), 1);
    step();

    s_axi_bready = 0;
    s_axi_awaddr = 32'h2C; s_axi_wdata = 32'h0BAD_F00D; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1; s_axi_wvalid = 1;
    step();
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    @(negedge user_clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge user_clk);
      chk("bstall_bvalid", s_axi_bvalid, 1);
      chk("bstall_awready", s_axi_awready, 0);
      chk("bstall_wready", s_axi_wready, 0);
    end
    step();
    s_axi_bready = 1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin @(negedge user_clk); if (s_axi_bvalid) cnt++; end
    chk("b_release_count", 32'(cnt), 1);
    step();
    rd(32'h2C, d, r);
    chk("scr3", d, 32'h0BAD_F00D);

    s_axi_awaddr = 32'h28; s_axi_awvalid = 1;
    step();
    s_axi_awvalid = 0; user_reset = 1;
    step();
    user_reset = 0;
    s_axi_wdata = 32'h0000_0077; s_axi_wstrb = 4'hF; s_axi_wvalid = 1;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin @(negedge user_clk); got = s_axi_wready; end
    step();
    s_axi_wvalid = 0;
    chk("w_after_reset", 32'(got), 1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin @(negedge user_clk); if (s_axi_bvalid) cnt++; end
    chk("no_b_after_reset", 32'(cnt), 0);
    step();
    rd(32'h28, d, r);
    chk("scr2_untouched", d, 32'h0);
    rd(32'h2C, d, r);
    chk("scr3_reset", d, 32'h0);
    s_axi_awaddr = 32'h28; s_axi_awvalid = 1;
    step();
    s_axi_awvalid = 0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin @(negedge user_clk); if (s_axi_bvalid) cnt++; end
    chk("held_w_commit", 32'(cnt), 1);
    step();
    rd(32'h28, d, r);
    chk("scr2_held_w", d, 32'h0000_0077);
    wr(32'h2C, 32'h1111_2222, 4'hF, 0, r, lat);
    rd(32'h2C, d, r);
    chk("resume_write", d, 32'h1111_2222);

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
